// File: rtl/ctrl_reg_desp.sv
// rtl/ctrl_reg_desp.sv - command sequencer driving a 4-bit shift/rotate/load register
module ctrl_reg_desp #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic             reg_enb,
  output logic [1:0]       reg_mode,
  output logic             reg_dir,
  output logic             reg_s_in,
  output logic [WIDTH-1:0] reg_d,
  input  logic             reg_s_out,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_ROT   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, n_cmd;
  logic [1:0]       op_q, op_nxt, mode_nxt;
  logic             dir_nxt, enb_nxt, done_nxt, err_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic             ready_q;
  logic             accept;

  // ready_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = (state == IDLE) && ready_q;
  assign accept    = cmd_valid && cmd_ready;
  assign ser_out   = reg_s_out;
  assign reg_s_in  = (state == EXEC && op_q == OP_SHIFT) ? ser_in : 1'b0;

  always_comb begin
    case (cmd_op)
      OP_LOAD:         n_cmd = CNT_W'(1);
      OP_SHIFT, OP_ROT: n_cmd = cmd_cnt;
      default:         n_cmd = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    op_nxt    = op_q;
    enb_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    mode_nxt  = reg_mode;
    dir_nxt   = reg_dir;
    d_nxt     = reg_d;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt  = cmd_op;
          cnt_nxt = n_cmd;
          if (cmd_op != OP_RSVD) begin
            mode_nxt = {cmd_op == OP_LOAD, cmd_op == OP_ROT};
            dir_nxt  = cmd_dir;
          end
          if (cmd_op == OP_LOAD) d_nxt = cmd_data;
          if (n_cmd != '0) begin
            state_nxt = EXEC;
            enb_nxt   = 1'b1;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = (cmd_op == OP_RSVD);
          end
        end
      end
      EXEC: begin
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          enb_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      ready_q       <= 1'b0;
      reg_enb       <= 1'b0;
      reg_mode      <= '0;
      reg_dir       <= 1'b0;
      reg_d         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      ser_out_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt_q         <= cnt_nxt;
      op_q          <= op_nxt;
      ready_q       <= 1'b1;
      reg_enb       <= enb_nxt;
      reg_mode      <= mode_nxt;
      reg_dir       <= dir_nxt;
      reg_d         <= d_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      // the register's s_out lags one edge behind its enabled shift step
      ser_out_valid <= reg_enb && (reg_mode == 2'b00);
    end
  end

endmodule

// File: tb/tb_ctrl_reg_desp.sv
// tb/tb_ctrl_reg_desp.sv - self-checking bench for ctrl_reg_desp with a behavioural register
module tb_ctrl_reg_desp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_dir, ser_in;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       reg_enb, reg_dir, reg_s_in, reg_s_out;
  logic [1:0] reg_mode;
  logic [3:0] reg_d;
  logic       ser_out, ser_out_valid, done, err;

  int checks = 0;
  int errors = 0;

  ctrl_reg_desp #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .ser_in(ser_in), .reg_enb(reg_enb), .reg_mode(reg_mode), .reg_dir(reg_dir),
    .reg_s_in(reg_s_in), .reg_d(reg_d), .reg_s_out(reg_s_out), .ser_out(ser_out),
    .ser_out_valid(ser_out_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // the controlled register; it has no reset, so contents survive a controller reset
  logic [3:0] rq = 4'd0;
  logic       rs_out = 1'b0;
  assign reg_s_out = rs_out;

  always @(posedge clk) begin
    if (reg_enb) begin
      case (reg_mode)
        2'b10: begin rq <= reg_d; rs_out <= 1'b0; end
        2'b00: begin
          if (reg_dir) begin rs_out <= rq[0]; rq <= {reg_s_in, rq[3:1]}; end
          else         begin rs_out <= rq[3]; rq <= {rq[2:0], reg_s_in}; end
        end
        2'b01: begin
          rs_out <= 1'b0;
          rq <= reg_dir ? {rq[0], rq[3:1]} : {rq[2:0], rq[3]};
        end
        default: rs_out <= 1'b0;
      endcase
    end else begin
      rs_out <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic [2:0] cnt;
    logic [3:0] data;
    logic [7:0] sin;
    int         n;
    int         nbits;
    logic [7:0] bits;
    logic       err;
    logic [3:0] exp_q;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: step count and emitted bits derived from the command rules with plain integers
  function automatic vec_t mk(input logic [1:0] op, input logic dir, input logic [2:0] cnt,
                              input logic [3:0] data, input logic [7:0] sin, input logic [3:0] q0);
    vec_t v;
    int q, b, s;
    v.op = op; v.dir = dir; v.cnt = cnt; v.data = data; v.sin = sin;
    v.n = (op == 2'd0) ? 1 : (op == 2'd3) ? 0 : int'(cnt);
    v.nbits = (op == 2'd1) ? v.n : 0;
    v.bits = 8'h00;
    v.err = (op == 2'd3);
    q = int'(q0);
    for (int i = 0; i < v.n; i++) begin
      s = int'(sin[i]);
      case (op)
        2'd0: q = int'(data);
        2'd1: begin
          b = dir ? q % 2 : q / 8;
          v.bits[i] = b[0];
          q = dir ? (q / 2 + s * 8) : ((q * 2 + s) % 16);
        end
        default: q = dir ? (q / 2 + (q % 2) * 8) : ((q * 2) % 16 + q / 8);
      endcase
    end
    v.exp_q = q[3:0];
    return v;
  endfunction

  task automatic wait_ready();
    int t;
    for (t = 0; t < 30; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (t == 30) chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input vec_t v);
    int seen, vcnt, done_at, bad;
    logic [7:0] got_bits;
    logic got_err, last_valid;
    logic [1:0] exp_mode;
    seen = 0; vcnt = 0; done_at = -1; bad = 0; got_bits = 8'h00;
    got_err = 1'b0; last_valid = 1'b0;
    exp_mode = (v.op == 2'd0) ? 2'b10 : (v.op == 2'd2) ? 2'b01 : 2'b00;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = v.op; cmd_dir = v.dir; cmd_cnt = v.cnt; cmd_data = v.data;
    ser_in = v.sin[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_dir = 1'($urandom); cmd_cnt = 3'($urandom); cmd_data = 4'($urandom);
    for (int t = 0; t < 24 && done_at < 0; t++) begin
      @(negedge clk);
      if (cmd_ready) bad++;
      if (reg_enb) begin
        if (reg_mode !== exp_mode || reg_dir !== v.dir) bad++;
        if (v.op == 2'd0 && reg_d !== v.data) bad++;
        if (reg_s_in !== ((v.op == 2'd1) ? ser_in : 1'b0)) bad++;
        seen++;
      end
      if (ser_out_valid) begin
        if (vcnt < 8) got_bits[vcnt] = ser_out;
        vcnt++;
      end
      if (done) begin done_at = t; got_err = err; last_valid = ser_out_valid; end
      @(posedge clk); #1;
      ser_in = (seen < 8) ? v.sin[seen] : 1'b0;
    end
    chk("exec_ctl", 32'(bad), 32'd0);
    chk("done_cycle", 32'(done_at), 32'(v.n));
    chk("enb_cycles", 32'(seen), 32'(v.n));
    chk("valid_count", 32'(vcnt), 32'(v.nbits));
    chk("ser_bits", 32'(got_bits), 32'(v.bits));
    chk("err", 32'(got_err), 32'(v.err));
    chk("last_valid_with_done", 32'(last_valid), 32'(v.op == 2'd1 && v.n > 0));
    @(negedge clk);
    chk("ready_after_done", 32'(cmd_ready), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("reg_q", 32'(rq), 32'(v.exp_q));
  endtask

  vec_t tbl[8];
  vec_t va, vb;
  logic [3:0] mq;
  int bad, k;

  initial begin
    tbl[0] = '{2'd0, 1'b0, 3'd0, 4'b1011, 8'h00, 1, 0, 8'h00,        1'b0, 4'b1011};
    tbl[1] = '{2'd1, 1'b0, 3'd4, 4'b0000, 8'h00, 4, 4, 8'b0000_1101, 1'b0, 4'b0000};
    tbl[2] = '{2'd0, 1'b1, 3'd5, 4'b1011, 8'hFF, 1, 0, 8'h00,        1'b0, 4'b1011};
    tbl[3] = '{2'd2, 1'b1, 3'd3, 4'b0000, 8'hFF, 3, 0, 8'h00,        1'b0, 4'b0111};
    tbl[4] = '{2'd1, 1'b1, 3'd0, 4'b0000, 8'hFF, 0, 0, 8'h00,        1'b0, 4'b0111};
    tbl[5] = '{2'd3, 1'b0, 3'd5, 4'b1111, 8'hFF, 0, 0, 8'h00,        1'b1, 4'b0111};
    tbl[6] = '{2'd1, 1'b1, 3'd6, 4'b0000, 8'h0D, 6, 6, 8'b0001_0111, 1'b0, 4'b0011};
    tbl[7] = '{2'd2, 1'b0, 3'd7, 4'b0000, 8'hFF, 7, 0, 8'h00,        1'b0, 4'b1001};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dir = 1'b0; cmd_cnt = 3'd0;
    cmd_data = 4'd0; ser_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {26'd0, reg_enb, reg_mode, reg_dir, done, err}, 32'd0);
    chk("rst_valid_d", {27'd0, ser_out_valid, reg_d}, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_cmd(tbl[i]);
    mq = 4'b1001;

    // reset during the second enabled cycle of a 4-step shift
    run_cmd(mk(2'd0, 1'b0, 3'd0, 4'b1011, 8'h00, mq));
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dir = 1'b0; cmd_cnt = 3'd4; ser_in = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_enb_first", 32'(reg_enb), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("mid_rst_enb_drop", {29'd0, reg_enb, done, cmd_ready}, 32'd0);
    bad = 0;
    repeat (2) begin @(negedge clk); if (done || reg_enb) bad++; end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) bad++;
    chk("mid_rst_no_done", 32'(bad), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_q_holds", 32'(rq), 32'h6);
    mq = 4'b0110;

    // back-to-back with cmd_valid held; fields switch to the second command right after accept
    va = mk(2'd1, 1'b0, 3'd2, 4'd0, 8'h00, mq);
    vb = mk(2'd2, 1'b1, 3'd1, 4'd0, 8'h00, va.exp_q);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dir = 1'b0; cmd_cnt = 3'd2; ser_in = 1'b0;
    @(posedge clk); #1;
    cmd_op = 2'd2; cmd_dir = 1'b1; cmd_cnt = 3'd1;
    bad = 0; k = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (reg_enb && reg_mode !== 2'b00) bad++;
      if (done) begin k = t; break; end
    end
    chk("b2b_first_mode", 32'(bad), 32'd0);
    chk("b2b_first_done", 32'(k), 32'd2);
    @(negedge clk);
    chk("b2b_idle_gap", {30'd0, cmd_ready, reg_enb}, 32'd2);
    @(negedge clk);
    chk("b2b_second_start", {28'd0, reg_enb, reg_mode, reg_dir}, 32'b1011);
    cmd_valid = 1'b0;
    k = -1;
    for (int t = 0; t < 20; t++) begin
      if (done) begin k = t; break; end
      @(negedge clk);
    end
    chk("b2b_second_done", 32'(k), 32'd1);
    @(negedge clk);
    chk("b2b_q", 32'(rq), 32'(vb.exp_q));
    mq = vb.exp_q;

    for (int i = 0; i < 40; i++) begin
      va = mk(2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 7)),
              4'($urandom), 8'($urandom), mq);
      run_cmd(va);
      mq = va.exp_q;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
